// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per clock, with a one-cycle done pulse and pipeline-flush kill.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          fn_q, fn_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [TAG_W-1:0]    tag_out_q, tag_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                a_neg_s, b_neg_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic                div_zero_s, div_ovf_s, last_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_next_s, prod_fin_s;
    logic [XLEN-1:0]     mul_res_s;
    logic [XLEN:0]       rem_sh_s, div_diff_s;
    logic                div_ge_s;
    logic [2*XLEN-1:0]   div_next_s;
    logic [XLEN-1:0]     quot_fin_s, rem_fin_s, div_res_s;

    // Operand decode at accept plus one multiply step and one divide step.
    always_comb begin
        a_neg_s    = (op[2] ? !op[0] : (op[1:0] != 2'b11)) && a[XLEN-1];
        b_neg_s    = (op[2] ? !op[0] : !op[1]) && b[XLEN-1];
        mag_a_s    = a_neg_s ? -a : a;
        mag_b_s    = b_neg_s ? -b : b;
        div_zero_s = (b == {XLEN{1'b0}});
        div_ovf_s  = !op[0] && (a == MOST_NEG) && (b == {XLEN{1'b1}});
        last_s     = (cnt_q == CNT_W'(XLEN - 1));

        // Multiply: low half holds the remaining multiplier bits, high half accumulates.
        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opd_q : {XLEN{1'b0}})};
        mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
        prod_fin_s = neg_q ? -mul_next_s : mul_next_s;
        mul_res_s  = (fn_q == 2'b00) ? prod_fin_s[XLEN-1:0] : prod_fin_s[2*XLEN-1:XLEN];

        // Divide: the shifted partial remainder needs one extra bit before the trial subtract.
        rem_sh_s   = acc_q[2*XLEN-1:XLEN-1];
        div_diff_s = rem_sh_s - {1'b0, opd_q};
        div_ge_s   = !div_diff_s[XLEN];
        div_next_s = {(div_ge_s ? div_diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge_s};
        quot_fin_s = neg_q ? -div_next_s[XLEN-1:0] : div_next_s[XLEN-1:0];
        rem_fin_s  = rem_neg_q ? -div_next_s[2*XLEN-1:XLEN] : div_next_s[2*XLEN-1:XLEN];
        div_res_s  = fn_q[1] ? rem_fin_s : quot_fin_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        fn_d      = fn_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !kill) begin
                    fn_d      = op[1:0];
                    tag_d     = tag_in;
                    cnt_d     = {CNT_W{1'b0}};
                    neg_d     = a_neg_s ^ b_neg_s;
                    rem_neg_d = a_neg_s;
                    if (op[2] && div_zero_s) begin
                        state_d   = S_DONE;
                        result_d  = op[1] ? a : {XLEN{1'b1}};
                        tag_out_d = tag_in;
                    end else if (op[2] && div_ovf_s) begin
                        state_d   = S_DONE;
                        result_d  = op[1] ? {XLEN{1'b0}} : a;
                        tag_out_d = tag_in;
                    end else if (op[2]) begin
                        state_d = S_DIV;
                        acc_d   = {{XLEN{1'b0}}, mag_a_s};
                        opd_d   = mag_b_s;
                    end else begin
                        state_d = S_MUL;
                        acc_d   = {{XLEN{1'b0}}, mag_b_s};
                        opd_d   = mag_a_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_next_s : div_next_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_s) begin
                        state_d   = S_DONE;
                        result_d  = (state_q == S_MUL) ? mul_res_s : div_res_s;
                        tag_out_d = tag_q;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fn_q      <= 2'b00;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            opd_q     <= {XLEN{1'b0}};
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            tag_q     <= {TAG_W{1'b0}};
            result_q  <= {XLEN{1'b0}};
            tag_out_q <= {TAG_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fn_q      <= fn_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, TAG_W=5).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .op      (op),
        .a       (a),
        .b       (b),
        .tag_in  (tag_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .tag_out (tag_out)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge, then count edges until done (bounded at 100).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t, output int lat, output int bcnt);
        op = o; a = x; b = y; tag_in = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; tag_in = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (tag_out !== 5'd0) begin errors++; $display("FAIL reset_tag: got %h expected 0", tag_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        int lat, bcnt;
        logic [2:0]  vo [4] = '{3'b011, 3'b001, 3'b010, 3'b000};
        logic [31:0] va [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        logic [31:0] ve [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, lat, bcnt);
        checks++; if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", result); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        checks++; if (bcnt !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 32", bcnt); end
        checks++; if (tag_out !== 5'd9) begin errors++; $display("FAIL mul_tag: got %0d expected 9", tag_out); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
        for (int i = 0; i < 4; i++) begin
            run_op(vo[i], va[i], vb[i], 5'(i), lat, bcnt);
            checks++;
            if (result !== ve[i]) begin
                errors++; $display("FAIL mul_vec%0d: got %h expected %h", i, result, ve[i]);
            end
        end
    endtask

    task automatic test_div;
        int lat, bcnt;
        logic [2:0]  vo [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] va [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] vb [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] ve [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        for (int i = 0; i < 6; i++) begin
            run_op(vo[i], va[i], vb[i], 5'(i + 10), lat, bcnt);
            checks++;
            if (result !== ve[i] || lat !== 33) begin
                errors++; $display("FAIL div_vec%0d: got %h lat %0d expected %h lat 33", i, result, lat, ve[i]);
            end
        end
    endtask

    task automatic test_special;
        int lat, bcnt;
        logic [2:0]  vo [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] va [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
        logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ve [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_op(vo[i], va[i], vb[i], 5'(i + 20), lat, bcnt);
            checks++;
            if (result !== ve[i] || lat !== 1 || tag_out !== 5'(i + 20)) begin
                errors++; $display("FAIL special_vec%0d: got %h lat %0d tag %0d expected %h lat 1 tag %0d",
                                   i, result, lat, tag_out, ve[i], i + 20);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        op = 3'b000; a = 32'd6; b = 32'd7; tag_in = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        op = 3'b101; a = 32'd100; b = 32'd7; tag_in = 5'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy); end
        wait_done(n);
        checks++;
        if (n !== 26 || result !== 32'd42 || tag_out !== 5'd1) begin
            errors++; $display("FAIL ignore_result: got %h tag %0d after %0d expected 0000002a tag 1 after 26",
                               result, tag_out, n);
        end
    endtask

    task automatic test_kill;
        int lat, bcnt;
        logic saw_done;
        op = 3'b100; a = 32'hFFFFFFF9; b = 32'd2; tag_in = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL kill_busy: got busy %b done %b expected 0 0", busy, done);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL kill_no_done: got %b expected 0", saw_done); end
        checks++; if (result !== 32'd42 || tag_out !== 5'd1) begin
            errors++; $display("FAIL kill_hold: got %h tag %0d expected 0000002a tag 1", result, tag_out);
        end
        run_op(3'b000, 32'd3, 32'd5, 5'd11, lat, bcnt);
        checks++; if (result !== 32'd15 || lat !== 33 || tag_out !== 5'd11) begin
            errors++; $display("FAIL kill_then_mul: got %h lat %0d tag %0d expected 0000000f lat 33 tag 11",
                               result, lat, tag_out);
        end
    endtask

    task automatic test_rst_mid;
        op = 3'b000; a = 32'd9; b = 32'd9; tag_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || tag_out !== 5'd0) begin
            errors++; $display("FAIL rst_mid: got busy %b done %b result %h tag %0d expected all zero",
                               busy, done, result, tag_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        op = 3'b000; a = 32'd2; b = 32'd3; tag_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        op = 3'b101; a = 32'd100; b = 32'd7; tag_in = 5'd6;
        wait_done(n);
        checks++; if (n !== 32 || result !== 32'd6 || tag_out !== 5'd4) begin
            errors++; $display("FAIL b2b_first: got %h tag %0d after %0d expected 00000006 tag 4 after 32",
                               result, tag_out, n);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy %b done %b expected 1 0", busy, done);
        end
        wait_done(n);
        checks++; if (n !== 32 || result !== 32'd14 || tag_out !== 5'd6) begin
            errors++; $display("FAIL b2b_second: got %h tag %0d after %0d expected 0000000e tag 6 after 32",
                               result, tag_out, n);
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_busy_ignore;
        test_kill;
        test_rst_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
